// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - CPU, cache array and main memory signal bundle for cache_controller
interface cache_controller_if;
  // CPU request side
  logic        cpu_read;
  logic        cpu_write;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        stall;

  // Cache data array side
  logic [3:0]  tag_v;
  logic        hit_or_miss;
  logic        cu_to_mem_write;
  logic        cu_to_cash_read;
  logic [9:0]  cache_addr;
  logic [31:0] cache_wdata;
  logic        ok;

  // Main memory side
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;

  // Controller view: consumes requests and status, drives every strobe
  modport master (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, tag_v, mem_ready, mem_rdata,
    output stall, hit_or_miss, cu_to_mem_write, cu_to_cash_read, cache_addr,
           cache_wdata, ok, mem_read, mem_write, mem_addr, mem_wdata
  );

  // Environment view: CPU, cache array and memory model around the controller
  modport slave (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, tag_v, mem_ready, mem_rdata,
    input  stall, hit_or_miss, cu_to_mem_write, cu_to_cash_read, cache_addr,
           cache_wdata, ok, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-through, no-allocate cache controller with 4-word line refill
module cache_controller (
  input  logic               clk,
  input  logic               reset,
  cache_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, REFILL, RESP, WRITE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [9:0]  addr_q;
  logic [31:0] wdata_q;
  logic        write_q;

  logic        req_any;
  logic [9:0]  sel_addr;
  logic        hit;

  logic        stall_c, hit_or_miss_c, cu_to_mem_write_c, cu_to_cash_read_c;
  logic        ok_c, mem_read_c, mem_write_c;
  logic [9:0]  mem_addr_c;
  logic [31:0] cache_wdata_c, mem_wdata_c;

  assign req_any = bus.cpu_read | bus.cpu_write;

  // The cache sees the live CPU address while idle and the captured one while a miss or store is in flight
  always_comb begin
    sel_addr = (state_q == IDLE) ? bus.cpu_addr : addr_q;
  end

  // Tag compare is against whatever address the cache array is currently being driven with
  assign hit = bus.tag_v[0] & (bus.tag_v[3:1] == sel_addr[9:7]);

  // State, beat counter and captured request; the request is re-captured on every idle cycle that carries one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      addr_q  <= 10'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (state_q == IDLE && req_any) begin
        addr_q  <= bus.cpu_addr;
        wdata_q <= bus.cpu_wdata;
        write_q <= bus.cpu_write;
      end
    end
  end

  // Next-state and strobe decode; stores win over loads when both are requested
  always_comb begin
    state_d           = state_q;
    beat_d            = beat_q;
    stall_c           = 1'b0;
    hit_or_miss_c     = 1'b0;
    cu_to_mem_write_c = 1'b0;
    cu_to_cash_read_c = 1'b0;
    cache_wdata_c     = 32'd0;
    ok_c              = 1'b0;
    mem_read_c        = 1'b0;
    mem_write_c       = 1'b0;
    mem_addr_c        = 10'd0;
    mem_wdata_c       = 32'd0;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_write) begin
          // Write-through: update the line only when it is present, then go post the word to memory
          stall_c = 1'b1;
          state_d = WRITE;
          if (hit) begin
            cu_to_mem_write_c = 1'b1;
            hit_or_miss_c     = 1'b1;
            cache_wdata_c     = bus.cpu_wdata;
          end
        end else if (bus.cpu_read) begin
          if (hit) begin
            cu_to_cash_read_c = 1'b1;
            hit_or_miss_c     = 1'b1;
          end else begin
            stall_c = 1'b1;
            beat_d  = 2'd0;
            state_d = REFILL;
          end
        end
      end

      REFILL: begin
        // Fetch the whole line word by word; a beat only counts when memory acknowledges it
        stall_c    = 1'b1;
        mem_read_c = 1'b1;
        mem_addr_c = {addr_q[9:2], beat_q};
        if (bus.mem_ready) begin
          cache_wdata_c     = bus.mem_rdata;
          cu_to_cash_read_c = 1'b1;
          beat_d            = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        // Line is complete: tell the cache and serve the original load from it
        ok_c              = 1'b1;
        cu_to_cash_read_c = 1'b1;
        hit_or_miss_c     = 1'b1;
        state_d           = IDLE;
      end

      WRITE: begin
        // Hold the store on the memory bus until memory takes it; the CPU is released in the ack cycle
        mem_write_c = write_q;
        mem_addr_c  = addr_q;
        mem_wdata_c = wdata_q;
        stall_c     = ~bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every output is held at zero while reset is high so nothing escapes even mid-transaction
  always_comb begin
    if (reset) begin
      bus.stall           = 1'b0;
      bus.hit_or_miss     = 1'b0;
      bus.cu_to_mem_write = 1'b0;
      bus.cu_to_cash_read = 1'b0;
      bus.cache_addr      = 10'd0;
      bus.cache_wdata     = 32'd0;
      bus.ok              = 1'b0;
      bus.mem_read        = 1'b0;
      bus.mem_write       = 1'b0;
      bus.mem_addr        = 10'd0;
      bus.mem_wdata       = 32'd0;
    end else begin
      bus.stall           = stall_c;
      bus.hit_or_miss     = hit_or_miss_c;
      bus.cu_to_mem_write = cu_to_mem_write_c;
      bus.cu_to_cash_read = cu_to_cash_read_c;
      bus.cache_addr      = sel_addr;
      bus.cache_wdata     = cache_wdata_c;
      bus.ok              = ok_c;
      bus.mem_read        = mem_read_c;
      bus.mem_write       = mem_write_c;
      bus.mem_addr        = mem_addr_c;
      bus.mem_wdata       = mem_wdata_c;
    end
  end

endmodule
